mig_app_responder: RTL
======================

# mig_app_responder

Synthesizable responder for the MIG user (app_*) interface: accepts the commands and write data that `mem_burst` issues, stores them in an on-chip array, and returns read data with a fixed latency. It replaces the `ddr3` controller instance in simulation and PHY-less bring-up builds, so `mem_burst` and `mem_test` run unchanged without external memory. It sits on `mem_clk`, on the far side of the app interface from `mem_burst`.

## Interface
- MEM_DATA_BITS, 256: app data width (2 × nCK_PER_CLK 4 × payload 32).
- MEM_IF_ADDR_BITS, 29: app_addr width.
- DEPTH_BITS, 10: log2 of the number of stored app words.
- RD_LATENCY, 4: cycles from read acceptance to app_rd_data_valid. Must be ≥1.
- CALIB_CYCLES, 1000: cycles after reset release before init_calib_complete rises.
- WDF_DEPTH, 4: write-data FIFO entries. Must be a power of 2.

- mem_clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- app_addr  in  MEM_IF_ADDR_BITS  command address; word index = app_addr[DEPTH_BITS+2:3]; bits [2:0] and bits above the index are ignored.
- app_cmd  in  3  3'b000 write, 3'b001 read; other codes are accepted and discarded.
- app_en  in  1  command valid.
- app_rdy  out  1  command accepted when app_en && app_rdy.
- app_wdf_data  in  MEM_DATA_BITS  write data.
- app_wdf_mask  in  MEM_DATA_BITS/8  1 = byte not written.
- app_wdf_wren  in  1  write-data valid; pushed when app_wdf_wren && app_wdf_rdy.
- app_wdf_end  in  1  ignored; every beat is a complete word.
- app_wdf_rdy  out  1  write FIFO can take a beat.
- app_rd_data  out  MEM_DATA_BITS  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- init_calib_complete  out  1  responder ready.

## Operation
- Reset values: init_calib_complete 0, app_rdy 0, app_wdf_rdy 0, app_rd_data_valid 0, app_rd_data_end 0, app_rd_data 0. FIFO and pipeline are emptied; array contents are undefined.
- Calibration counter counts CALIB_CYCLES after rst_n rises. init_calib_complete is registered and then stays at 1 until reset.
- Write FIFO: WDF_DEPTH entries of {data, mask}. app_wdf_rdy = init_calib_complete && (count < WDF_DEPTH).
- States: CALIB → READY. READY → WAIT_WDATA when a write is accepted with no data available. WAIT_WDATA → READY when a data beat is pushed; the write commits on that edge.
- app_rdy = init_calib_complete && state==READY && !stall.
- Write acceptance:
  - Data is taken from the FIFO head.
  - If the FIFO is empty and a beat is pushed in the same cycle, that beat bypasses the FIFO.
  - If the FIFO is empty and no beat is pushed, the state moves to WAIT_WDATA and the address is latched.
  - Masked bytes keep their old value.
- Read acceptance: the array is sampled on the acceptance edge, then delayed through an (RD_LATENCY-1)-stage valid/data pipeline. Reads complete in order.
- Data beats pushed with no write command pending stay in the FIFO for later writes. This is the MIG "data before command" case.

## Timing
- A write commits at the edge that ends its acceptance cycle (or its WAIT_WDATA push cycle).
- A read accepted in the cycle after a write to the same index returns the new data.
- A read accepted on edge N gives app_rd_data_valid high during cycle N+RD_LATENCY, for exactly one cycle per read.
- Back-to-back reads produce back-to-back valid cycles.
- FIFO full: app_wdf_rdy is low in the following cycle. A pop and a push in the same cycle leave the count unchanged, and app_wdf_rdy stays high.
- Wrap-around: addresses beyond 2^DEPTH_BITS words alias modulo the array size.
- rst_n asserted mid-operation: all outputs return to reset values immediately (asynchronously), pending reads are dropped, and calibration restarts.

## Configuration
- MIG_RESP_STALL_EN defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle after calibration.
  - stall = (lfsr[1:0]==2'b00), which forces app_rdy low.
  - app_wdf_rdy is additionally low when lfsr[3:2]==2'b00.
  - Purpose: exercise mem_burst backpressure.
- Not defined: stall = 0, and no LFSR is instantiated.

## Test plan
- Reset release, CALIB_CYCLES=1000 → init_calib_complete rises exactly 1000 cycles after rst_n rises; app_rdy, app_wdf_rdy, app_rd_data_valid are all 0 until then.
- Write with same-cycle data, 0x11..11 at addr 0x08, then read addr 0x08 in the next cycle → app_rd_data = 0x11..11 with valid on cycle acceptance+4; app_rd_data_end matches valid.
- Write addr 0x10 with no data → app_rdy low; data beat pushed 3 cycles later → app_rdy high the next cycle; readback matches the pushed data.
- Four data beats pushed, then four writes → app_wdf_rdy low after the 4th push; writes commit in order; readback of 4 addresses is correct.
- Mask 32'hFFFF_FFFE over a word of 0xFF..FF writing 0x00..00 → only byte 0 becomes 0x00.
- Reads to addr 0 and addr (1<<13) with DEPTH_BITS=10 → both return the same word; with MIG_RESP_STALL_EN defined, mem_test runs 10000 bursts with error staying 0.

Source files
------------

// File: rtl/mig_app_responder.sv
// rtl/mig_app_responder.sv - MIG app-interface responder backed by an on-chip array
// Optional MIG_RESP_STALL_EN adds LFSR-driven backpressure on app_rdy/app_wdf_rdy.
module mig_app_responder #(
    parameter int MEM_DATA_BITS    = 256,
    parameter int MEM_IF_ADDR_BITS = 29,
    parameter int DEPTH_BITS       = 10,
    parameter int RD_LATENCY       = 4,
    parameter int CALIB_CYCLES     = 1000,
    parameter int WDF_DEPTH        = 4
) (
    input  logic                          mem_clk,
    input  logic                          rst_n,
    input  logic [MEM_IF_ADDR_BITS-1:0]   app_addr,
    input  logic [2:0]                    app_cmd,
    input  logic                          app_en,
    output logic                          app_rdy,
    input  logic [MEM_DATA_BITS-1:0]      app_wdf_data,
    input  logic [MEM_DATA_BITS/8-1:0]    app_wdf_mask,
    input  logic                          app_wdf_wren,
    input  logic                          app_wdf_end,
    output logic                          app_wdf_rdy,
    output logic [MEM_DATA_BITS-1:0]      app_rd_data,
    output logic                          app_rd_data_valid,
    output logic                          app_rd_data_end,
    output logic                          init_calib_complete
);

    localparam int NBYTES = MEM_DATA_BITS / 8;
    localparam int CNT_W  = $clog2(CALIB_CYCLES + 1);
    localparam int PTR_W  = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
    localparam int FCNT_W = $clog2(WDF_DEPTH + 1);

    localparam logic [1:0] ST_CALIB      = 2'd0;
    localparam logic [1:0] ST_READY      = 2'd1;
    localparam logic [1:0] ST_WAIT_WDATA = 2'd2;

    logic [1:0]             state;
    logic [CNT_W-1:0]       calib_cnt;
    logic                   calib_done;
    logic [DEPTH_BITS-1:0]  pend_idx;
    logic [DEPTH_BITS-1:0]  addr_idx;
    logic                   stall;
    logic                   wdf_block;

    logic [MEM_DATA_BITS-1:0] mem [2**DEPTH_BITS];

    logic [MEM_DATA_BITS-1:0] wdf_data_q [WDF_DEPTH];
    logic [NBYTES-1:0]        wdf_mask_q [WDF_DEPTH];
    logic [PTR_W-1:0]         wdf_wr_ptr;
    logic [PTR_W-1:0]         wdf_rd_ptr;
    logic [FCNT_W-1:0]        wdf_count;
    logic                     wdf_empty;

    logic cmd_acc, wr_acc, rd_acc;
    logic wdf_push, wdf_pop, bypass, fifo_in;

    logic                     commit_en;
    logic [DEPTH_BITS-1:0]    commit_idx;
    logic [MEM_DATA_BITS-1:0] commit_data;
    logic [NBYTES-1:0]        commit_mask;

    logic [RD_LATENCY-1:0]    rd_vld;
    logic [MEM_DATA_BITS-1:0] rd_dat [RD_LATENCY];

    logic unused_ok;
    assign unused_ok = &{1'b0, app_wdf_end, app_addr[MEM_IF_ADDR_BITS-1:DEPTH_BITS+3], app_addr[2:0]};

`ifdef MIG_RESP_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16/14/13/11; frozen until calibration completes
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else if (calib_done) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall     = (lfsr[1:0] == 2'b00);
    assign wdf_block = (lfsr[3:2] == 2'b00);
`else
    assign stall     = 1'b0;
    assign wdf_block = 1'b0;
`endif

    assign addr_idx    = app_addr[DEPTH_BITS+2:3];
    assign wdf_empty   = (wdf_count == '0);
    assign app_rdy     = calib_done && (state == ST_READY) && !stall;
    assign app_wdf_rdy = calib_done && (wdf_count < FCNT_W'(WDF_DEPTH)) && !wdf_block;

    assign cmd_acc  = app_en && app_rdy;
    assign wr_acc   = cmd_acc && (app_cmd == 3'b000);
    assign rd_acc   = cmd_acc && (app_cmd == 3'b001);
    assign wdf_push = app_wdf_wren && app_wdf_rdy;
    assign wdf_pop  = wr_acc && !wdf_empty;

    // A beat arriving while the FIFO is empty and a write is waiting for it skips the FIFO
    assign bypass  = wdf_push && ((wr_acc && wdf_empty) || (state == ST_WAIT_WDATA));
    assign fifo_in = wdf_push && !bypass;

    assign init_calib_complete = calib_done;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CALIB;
            calib_cnt  <= '0;
            calib_done <= 1'b0;
            pend_idx   <= '0;
        end else begin
            case (state)
                ST_CALIB: begin
                    if (calib_cnt == CNT_W'(CALIB_CYCLES - 1)) begin
                        calib_done <= 1'b1;
                        state      <= ST_READY;
                    end else begin
                        calib_cnt <= calib_cnt + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (wr_acc && wdf_empty && !wdf_push) begin
                        state    <= ST_WAIT_WDATA;
                        pend_idx <= addr_idx;
                    end
                end
                ST_WAIT_WDATA: begin
                    if (wdf_push) begin
                        state <= ST_READY;
                    end
                end
                default: state <= ST_CALIB;
            endcase
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            wdf_wr_ptr <= '0;
            wdf_rd_ptr <= '0;
            wdf_count  <= '0;
        end else begin
            if (fifo_in) begin
                wdf_wr_ptr <= (wdf_wr_ptr == PTR_W'(WDF_DEPTH - 1)) ? '0 : wdf_wr_ptr + PTR_W'(1);
            end
            if (wdf_pop) begin
                wdf_rd_ptr <= (wdf_rd_ptr == PTR_W'(WDF_DEPTH - 1)) ? '0 : wdf_rd_ptr + PTR_W'(1);
            end
            case ({fifo_in, wdf_pop})
                2'b10:   wdf_count <= wdf_count + FCNT_W'(1);
                2'b01:   wdf_count <= wdf_count - FCNT_W'(1);
                default: wdf_count <= wdf_count;
            endcase
        end
    end

    always_ff @(posedge mem_clk) begin
        if (fifo_in) begin
            wdf_data_q[wdf_wr_ptr] <= app_wdf_data;
            wdf_mask_q[wdf_wr_ptr] <= app_wdf_mask;
        end
    end

    always_comb begin
        commit_en   = 1'b0;
        commit_idx  = addr_idx;
        commit_data = app_wdf_data;
        commit_mask = app_wdf_mask;
        if ((state == ST_WAIT_WDATA) && wdf_push) begin
            commit_en  = 1'b1;
            commit_idx = pend_idx;
        end else if (wr_acc) begin
            if (!wdf_empty) begin
                commit_en   = 1'b1;
                commit_data = wdf_data_q[wdf_rd_ptr];
                commit_mask = wdf_mask_q[wdf_rd_ptr];
            end else if (wdf_push) begin
                commit_en = 1'b1;
            end
        end
    end

    // Mask bit set means the byte keeps its previous contents
    always_ff @(posedge mem_clk) begin
        if (commit_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (!commit_mask[b]) begin
                    mem[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_dat[i] <= '0;
            end
        end else begin
            rd_vld[0] <= rd_acc;
            if (rd_acc) begin
                rd_dat[0] <= mem[addr_idx];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_dat[i] <= rd_dat[i-1];
            end
        end
    end

    assign app_rd_data       = rd_dat[RD_LATENCY-1];
    assign app_rd_data_valid = rd_vld[RD_LATENCY-1];
    assign app_rd_data_end   = rd_vld[RD_LATENCY-1];

endmodule
